// File: rtl/vga_rx_ctrl.sv
// VGA receive front end: recovers pixel coordinates from hsync/vsync, checks line/frame timing and locks.
// Latency 2 vga_clk edges input to output; no backpressure, the pixel stream is free-running.
module vga_rx_ctrl #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_VALID     = 640,
    parameter int V_VALID     = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] rgb,
    input  logic        hsync,
    input  logic        vsync,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    localparam logic [9:0]  CNT_MAX = 10'h3FF;
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] H_LO    = 11'(H_START);
    localparam logic [10:0] H_HI    = 11'(H_START + H_VALID);
    localparam logic [10:0] V_LO    = 11'(V_START);
    localparam logic [10:0] V_HI    = 11'(V_START + V_VALID);
    localparam logic [9:0]  H_OFF   = 10'(H_START);
    localparam logic [9:0]  V_OFF   = 10'(V_START);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCK} state_t;

    state_t      state;
    logic [7:0]  good_cnt;
    logic [15:0] rgb_s;
    logic        hs_s, vs_s, hs_d, vs_d;
    logic        hs_rise, vs_rise;
    logic [9:0]  pos_prev, line_prev;
    logic [9:0]  pos_cur, line_cur;
    logic        line_bad, frame_bad, pos_sat_evt, line_sat_evt, viol;
    logic        lock_ok, h_act, v_act, act;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb_s <= '0;
            hs_s  <= 1'b0;
            vs_s  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            rgb_s <= rgb;
            hs_s  <= hsync;
            vs_s  <= vsync;
            hs_d  <= hs_s;
            vs_d  <= vs_s;
        end
    end

    assign hs_rise = hs_s & ~hs_d;
    assign vs_rise = vs_s & ~vs_d;

    // pos_cur/line_cur are the coordinates of the sample currently held in rgb_s
    always_comb begin
        pos_cur  = (pos_prev == CNT_MAX) ? CNT_MAX : pos_prev + 10'd1;
        line_cur = line_prev;
        if (hs_rise) begin
            pos_cur = '0;
            if (line_prev != CNT_MAX)
                line_cur = line_prev + 10'd1;
        end
        if (vs_rise)
            line_cur = '0;
    end

    // Saturation is flagged only on the cycle a counter first hits the ceiling
    assign line_bad     = hs_rise && (({1'b0, pos_prev} + 11'd1) != H_TOT);
    assign frame_bad    = vs_rise && (({1'b0, line_prev} + 11'd1) != V_TOT);
    assign pos_sat_evt  = (pos_cur == CNT_MAX) && (pos_prev != CNT_MAX);
    assign line_sat_evt = (line_cur == CNT_MAX) && (line_prev != CNT_MAX);
    assign viol         = line_bad | frame_bad | pos_sat_evt | line_sat_evt;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pos_prev  <= '0;
            line_prev <= '0;
        end else begin
            pos_prev  <= pos_cur;
            line_prev <= line_cur;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                // Any vsync rise starts a check, even one that breaks the frame length
                SEARCH: begin
                    if (vs_rise) begin
                        state    <= CHECK;
                        good_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (viol) begin
                        state <= SEARCH;
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                    end else if (vs_rise) begin
                        good_cnt <= good_cnt + 8'd1;
                        if ((good_cnt + 8'd1) >= LOCK_N) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (viol) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // A violating sample is dropped so nothing leaks out of a broken frame
    assign lock_ok = (state == LOCK) && !viol;
    assign h_act   = ({1'b0, pos_cur} >= H_LO) && ({1'b0, pos_cur} < H_HI);
    assign v_act   = ({1'b0, line_cur} >= V_LO) && ({1'b0, line_cur} < V_HI);
    assign act     = lock_ok && h_act && v_act;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data    <= '0;
            pix_x       <= CNT_MAX;
            pix_y       <= CNT_MAX;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= act;
            pix_data    <= act ? rgb_s : 16'h0000;
            pix_x       <= act ? (pos_cur - H_OFF) : CNT_MAX;
            pix_y       <= act ? (line_cur - V_OFF) : CNT_MAX;
            frame_start <= act && (pos_cur == H_OFF) && (line_cur == V_OFF);
        end
    end

endmodule

// File: tb/tb_vga_rx_ctrl.sv
// Directed bench for vga_rx_ctrl on a reduced 40x20 timing so that several frames fit in a short run.
module tb_vga_rx_ctrl;

    localparam int HT = 40;
    localparam int VT = 20;
    localparam int HS = 8;
    localparam int VS = 4;
    localparam int HV = 24;
    localparam int VV = 12;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [15:0] rgb = '0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic        frame_start;
    logic        locked;
    logic [7:0]  err_cnt;

    vga_rx_ctrl #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .H_VALID(HV), .V_VALID(VV), .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Running frame monitor: pixel history two steps deep matches the DUT latency
    bit          mon_en = 1'b0;
    bit          exp_lock = 1'b0;
    int          n_valid = 0;
    int          n_fs = 0;
    int          n_err = 0;
    bit          a1 = 1'b0, a2 = 1'b0;
    logic [15:0] d1 = '0, d2 = '0;
    logic [9:0]  x1 = '0, x2 = '0, y1 = '0, y2 = '0;

    task automatic px(input logic hs, input logic vs, input logic [15:0] d, input int h, input int v);
        bit act;
        @(negedge vga_clk);
        if (mon_en) begin
            if (pix_valid) n_valid++;
            if (frame_start) n_fs++;
            if (a2) begin
                if (pix_valid !== 1'b1 || pix_data !== d2 || pix_x !== x2 || pix_y !== y2) n_err++;
            end else if (pix_valid !== 1'b0 || pix_data !== 16'h0000 ||
                         pix_x !== 10'h3FF || pix_y !== 10'h3FF) begin
                n_err++;
            end
            if (frame_start !== (a2 && x2 == 10'd0 && y2 == 10'd0)) n_err++;
        end
        act = exp_lock && h >= HS && h < HS + HV && v >= VS && v < VS + VV;
        a2 = a1; d2 = d1; x2 = x1; y2 = y1;
        a1 = act; d1 = d; x1 = 10'(h - HS); y1 = 10'(v - VS);
        hsync = hs;
        vsync = vs;
        rgb   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 1'b0, 16'h0000, -1, -1);
    endtask

    task automatic mon_clear();
        n_valid = 0;
        n_fs = 0;
        n_err = 0;
    endtask

    task automatic frame(input int short_v, input bit lk_chk, input bit ovr);
        for (int v = 0; v < VT; v++) begin
            int len;
            len = (v == short_v) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic [15:0] d;
                d = {5'(v - VS), 11'(h - HS)};
                if (ovr && h == HS && v == VS) d = 16'hF800;
                px(h < 4, v < 2, d, h, v);
                if (lk_chk && v == 0 && h == 1) check("lock_early", locked, 0);
                if (lk_chk && v == 0 && h == 2) check("lock_rise", locked, 1);
                if (ovr && v == VS && h == HS + 2) begin
                    check("org_valid", pix_valid, 1);
                    check("org_x", pix_x, 10'd0);
                    check("org_y", pix_y, 10'd0);
                    check("org_data", pix_data, 16'hF800);
                    check("org_fs", frame_start, 1);
                end
                if (short_v >= 0 && v == short_v && h == 20) check("short_pre_vld", pix_valid, 1);
                if (short_v >= 0 && v == short_v + 1) begin
                    if (h == 1) check("short_lock_hold", locked, 1);
                    if (h == 2) begin
                        check("short_lock_drop", locked, 0);
                        check("short_err", err_cnt, 8'd1);
                    end
                    if (h == 20) check("short_post_vld", pix_valid, 0);
                end
            end
        end
    endtask

    task automatic check_reset_vals();
        check("rst_data", pix_data, 16'h0000);
        check("rst_x", pix_x, 10'h3FF);
        check("rst_y", pix_y, 10'h3FF);
        check("rst_valid", pix_valid, 0);
        check("rst_fs", frame_start, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err_cnt, 8'h00);
    endtask

    task automatic viol_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            px(1'b0, 1'b1, 16'h0000, -1, -1);
            px(1'b0, 1'b0, 16'h0000, -1, -1);
            px(1'b0, 1'b1, 16'h0000, -1, -1);
            px(1'b0, 1'b0, 16'h0000, -1, -1);
        end
    endtask

    initial begin
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(negedge vga_clk);
        sys_rst_n = 1'b1;
        idle(10);

        // Acquisition: search rise, then two good frames
        frame(-1, 1'b0, 1'b0);
        frame(-1, 1'b0, 1'b0);
        check("lock_after_f2", locked, 0);
        exp_lock = 1'b1;
        mon_clear();
        mon_en = 1'b1;
        frame(-1, 1'b1, 1'b1);
        mon_en = 1'b0;
        check("f3_valid_cnt", n_valid, HV * VV);
        check("f3_fs_cnt", n_fs, 1);
        check("f3_pixel_err", n_err, 0);

        // One short line while locked, then re-acquisition
        exp_lock = 1'b0;
        frame(10, 1'b0, 1'b0);
        mon_clear();
        mon_en = 1'b1;
        frame(-1, 1'b0, 1'b0);
        frame(-1, 1'b0, 1'b0);
        mon_en = 1'b0;
        check("relock_gap_valid", n_valid, 0);
        check("relock_gap_fs", n_fs, 0);
        check("relock_gap_err", n_err, 0);
        check("relock_gap_locked", locked, 0);
        exp_lock = 1'b1;
        mon_clear();
        mon_en = 1'b1;
        frame(-1, 1'b1, 1'b0);
        mon_en = 1'b0;
        check("relock_valid_cnt", n_valid, HV * VV);
        check("relock_fs_cnt", n_fs, 1);
        check("relock_pixel_err", n_err, 0);
        check("relock_err_cnt", err_cnt, 8'd1);

        // hsync stuck low long enough to saturate the position counter
        exp_lock = 1'b0;
        check("stuck_pre_locked", locked, 1);
        idle(1100);
        check("stuck_locked", locked, 0);
        check("stuck_err_cnt", err_cnt, 8'd2);

        // Lock again, then reset in the middle of an active line
        frame(-1, 1'b0, 1'b0);
        frame(-1, 1'b0, 1'b0);
        frame(-1, 1'b1, 1'b0);
        for (int i = 0; i < 6 * HT + 16; i++) begin
            int h, v;
            h = i % HT;
            v = i / HT;
            px(h < 4, v < 2, {5'(v - VS), 11'(h - HS)}, h, v);
        end
        check("mid_valid", pix_valid, 1);
        check("mid_x", pix_x, 10'd5);
        check("mid_y", pix_y, 10'd2);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals();
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (2) @(negedge vga_clk);
        sys_rst_n = 1'b1;
        idle(5);
        frame(-1, 1'b0, 1'b0);
        frame(-1, 1'b0, 1'b0);
        check("post_rst_locked", locked, 0);
        frame(-1, 1'b1, 1'b0);
        check("post_rst_err", err_cnt, 8'd0);

        // Repeated forced violations: exact count first, then saturation
        viol_pairs(10);
        idle(2);
        check("err_cnt_10", err_cnt, 8'd10);
        viol_pairs(290);
        idle(2);
        check("err_cnt_sat", err_cnt, 8'hFF);
        check("err_locked", locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rx_ctrl.md
VGA_RX_CTRL -- requirements
Module: vga_rx_ctrl

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel clocks per line, hsync rise to hsync rise.
REQ-002 Parameter V_TOTAL, default 525, lines per frame, vsync rise to vsync rise.
REQ-003 Parameter H_START, default 144, line position of the first active pixel (sync 96 + back 40 + left border 8).
REQ-004 Parameter V_START, default 35, frame line of the first active line (sync 2 + back 25 + top border 8).
REQ-005 Parameters H_VALID / V_VALID, defaults 640 / 480, active width and height.
REQ-006 Parameter LOCK_FRAMES, default 2, consecutive good frames required before lock.
REQ-007 vga_clk  input  1  pixel clock; the only clock; all logic on its rising edge.
REQ-008 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 rgb  input  16  RGB565 pixel from the transmitter, synchronous to vga_clk.
REQ-010 hsync / vsync  input  1 each  sync inputs, active-high.
REQ-011 pix_data  output  16  captured active pixel; 16'h0000 outside the active area.
REQ-012 pix_x / pix_y  output  10 each  active-area coordinate of pix_data; 10'h3FF when not valid.
REQ-013 pix_valid  output  1  pix_data/pix_x/pix_y describe an active pixel.
REQ-014 frame_start  output  1  one-cycle pulse with the pixel at (0,0).
REQ-015 locked  output  1  timing matches H_TOTAL/V_TOTAL.
REQ-016 err_cnt  output  8  saturating count of timing violations.

Function
REQ-017 rgb, hsync and vsync SHALL be registered once (sample stage); hsync and vsync SHALL also be registered a second time for edge detection.
REQ-018 An hsync rise is sampled hsync 1 while the previous sample is 0; that sample SHALL be line position 0. Otherwise the position SHALL increment by 1 and saturate at 1023.
REQ-019 On a vsync rise, the current line SHALL become frame line 0. On each hsync rise otherwise, the line counter SHALL increment by 1 and saturate at 1023.
REQ-020 Output registers SHALL update one cycle after the sample stage, giving a total latency of 2 vga_clk edges from input to output.
REQ-021 FSM states: SEARCH, CHECK, LOCK; reset state is SEARCH.
REQ-022 SEARCH: a vsync rise SHALL go to CHECK and clear the good-frame counter.
REQ-023 Line check: at each hsync rise, previous line position + 1 SHALL equal H_TOTAL; otherwise it is a violation.
REQ-024 Frame check: at each vsync rise, previous line count + 1 SHALL equal V_TOTAL; otherwise it is a violation.
REQ-025 A saturated line position (1023) or line counter (1023) SHALL be a violation and is signalled once per saturation episode.
REQ-026 CHECK: each violation-free frame, ending at a vsync rise, SHALL increment the good-frame counter; reaching LOCK_FRAMES SHALL go to LOCK.
REQ-027 A violation in CHECK or LOCK SHALL go to SEARCH and increment err_cnt, which saturates at 8'hFF.
REQ-028 A violation and a vsync rise in the same cycle SHALL be treated as a violation; no good frame is counted.
REQ-029 A vsync rise that causes the violation SHALL return the FSM to SEARCH and SHALL NOT also count as the SEARCH-to-CHECK vsync rise.
REQ-030 locked SHALL be 1 exactly while the state is LOCK; it SHALL be registered and change the cycle after the transition.
REQ-031 pix_valid SHALL be 1 only in LOCK, for H_START ≤ position < H_START+H_VALID and V_START ≤ line < V_START+V_VALID.
REQ-032 When pix_valid is 1: pix_x = position − H_START, pix_y = line − V_START, pix_data = sampled rgb.
REQ-033 frame_start SHALL pulse with pix_valid when pix_x = 0 and pix_y = 0; it is never asserted outside LOCK.
REQ-034 Entering SEARCH from LOCK SHALL force pix_valid to 0 from the next cycle, with no partial-frame pixels.

Reset
REQ-035 Asserting sys_rst_n low at any time, including mid-frame, SHALL immediately force: state SEARCH, all counters 0, pix_data 16'h0000, pix_x and pix_y 10'h3FF, pix_valid 0, frame_start 0, locked 0, err_cnt 8'h00, sync history 0.
REQ-036 After release, the FSM SHALL require a fresh vsync rise plus LOCK_FRAMES good frames before locked rises.

Verification
REQ-037 Stimulus: ideal 800x525 stream with rgb = {pix_y[4:0], pix_x[10:0] truncated} pattern. Response: locked rises 1 cycle after the 3rd vsync rise (SEARCH rise + 2 good frames); next frame yields exactly 307200 pix_valid cycles and one frame_start.
REQ-038 Stimulus: locked, then rgb 16'hF800 driven at the sample of position 144, line 35. Response: 2 edges later pix_valid=1, pix_x=0, pix_y=0, pix_data=16'hF800, frame_start=1.
REQ-039 Stimulus: locked, then one line shortened to 799 clocks. Response: locked=0 after that hsync rise, err_cnt=1, pix_valid stays 0 until re-lock 2 full frames after the next vsync rise.
REQ-040 Stimulus: hsync held low 1100 clocks. Response: exactly one violation, err_cnt +1, state SEARCH.
REQ-041 Stimulus: 300 forced violations. Response: err_cnt saturates at 8'hFF.
REQ-042 Stimulus: sys_rst_n pulsed low mid-active-line while locked. Response: all outputs at reset values during reset, asynchronously; after release, re-lock takes the full REQ-036 sequence.
